// File: rtl/frame_ram_writer_pkg.sv
// frame_ram_writer_pkg: shared LED frame geometry constants and the writer FSM state type
package litspin_pkg;
    localparam int LEDS_PER_HALF   = 16;
    localparam int HALVES          = 2;
    localparam int COLORS          = 3;
    localparam int ANGLES          = 64;
    localparam int BYTES_PER_ANGLE = 96;
    localparam int BYTES_PER_HALF  = LEDS_PER_HALF * COLORS;
    localparam int BANK_OFFSET     = 8192;
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;
endpackage

// File: rtl/frame_ram_writer_if.sv
// frame_ram_writer_if: byte stream handshake into the frame RAM writer
interface frame_ram_writer_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       sof;
    logic       data_ready;
    modport master (output data_in, data_valid, sof, input data_ready);
    modport slave  (input data_in, data_valid, sof, output data_ready);
endinterface

// File: rtl/frame_addr_calc.sv
// frame_addr_calc: frame offset of one colour byte, same mapping as the LED read side
module frame_addr_calc
    import litspin_pkg::*;
#(
    parameter int CURRENT_LED_WIDTH = 4,
    parameter int ANGLE_WIDTH       = 6,
    parameter int W_ADDR_WIDTH      = 14
) (
    input  logic [ANGLE_WIDTH-1:0]       i_angle,
    input  logic                         i_half,
    input  logic [CURRENT_LED_WIDTH-1:0] i_led,
    input  logic [1:0]                   i_color,
    output logic [W_ADDR_WIDTH-1:0]      o_offset
);
    assign o_offset = W_ADDR_WIDTH'(i_angle) * W_ADDR_WIDTH'(BYTES_PER_ANGLE)
                    + W_ADDR_WIDTH'(i_half) * W_ADDR_WIDTH'(BYTES_PER_HALF)
                    + W_ADDR_WIDTH'(i_led) * W_ADDR_WIDTH'(COLORS)
                    + W_ADDR_WIDTH'(i_color);
endmodule

// File: rtl/frame_ram_writer.sv
// frame_ram_writer: writes an sof-framed colour byte stream into frame RAM; FRAME_DOUBLE_BUFFER_EN enables bank ping-pong
module frame_ram_writer
    import litspin_pkg::*;
#(
    parameter int CURRENT_LED_WIDTH = 4,
    parameter int ANGLE_WIDTH       = 6,
    parameter int W_ADDR_WIDTH      = 14
) (
    input  logic                    clk,
    input  logic                    nrst,
    frame_ram_writer_if.slave       s_if,
    output logic                    w_en,
    output logic [W_ADDR_WIDTH-1:0] w_addr,
    output logic [7:0]              w_data,
    output logic                    rd_bank,
    output logic                    frame_done,
    output logic                    sync_err
);
    state_t                         r_state;
    logic [ANGLE_WIDTH-1:0]         r_angle, w_angle, w_n_angle;
    logic                           r_half, w_half, w_n_half;
    logic [CURRENT_LED_WIDTH-1:0]   r_led, w_led, w_n_led;
    logic [1:0]                     r_color, w_color, w_n_color;
    logic                           w_acc, w_wr, w_sof_err, w_last;
    logic                           w_c_wrap, w_l_wrap, w_h_wrap, w_a_wrap;
    logic                           w_write_bank;
    logic [W_ADDR_WIDTH-1:0]        w_offset;

    assign s_if.data_ready = r_state != ST_DONE;
    assign frame_done      = r_state == ST_DONE;

`ifdef FRAME_DOUBLE_BUFFER_EN
    logic r_rd_bank;
    assign rd_bank      = r_rd_bank;
    assign w_write_bank = ~r_rd_bank;
    // hand the just-completed bank to the reader as the FSM leaves DONE
    always_ff @(posedge clk) begin
        if (!nrst)
            r_rd_bank <= 1'b0;
        else if (r_state == ST_DONE)
            r_rd_bank <= ~r_rd_bank;
    end
`else
    assign rd_bank      = 1'b0;
    assign w_write_bank = 1'b0;
`endif

    // an sof byte always lands at offset 0, so it selects zero indices instead of the counters
    always_comb begin
        w_acc     = s_if.data_valid && s_if.data_ready;
        w_wr      = w_acc && (s_if.sof || r_state == ST_WRITE);
        w_sof_err = w_acc && s_if.sof && r_state == ST_WRITE;
        w_angle   = s_if.sof ? '0 : r_angle;
        w_half    = s_if.sof ? 1'b0 : r_half;
        w_led     = s_if.sof ? '0 : r_led;
        w_color   = s_if.sof ? 2'd0 : r_color;
        w_c_wrap  = w_color == 2'(COLORS - 1);
        w_l_wrap  = w_led == CURRENT_LED_WIDTH'(LEDS_PER_HALF - 1);
        w_h_wrap  = w_half == 1'(HALVES - 1);
        w_a_wrap  = w_angle == ANGLE_WIDTH'(ANGLES - 1);
        w_last    = w_c_wrap && w_l_wrap && w_h_wrap && w_a_wrap;
        w_n_color = w_c_wrap ? 2'd0 : w_color + 2'd1;
        w_n_led   = !w_c_wrap ? w_led : w_l_wrap ? '0 : w_led + 1'b1;
        w_n_half  = !(w_c_wrap && w_l_wrap) ? w_half : w_h_wrap ? 1'b0 : w_half + 1'b1;
        w_n_angle = !(w_c_wrap && w_l_wrap && w_h_wrap) ? w_angle : w_a_wrap ? '0 : w_angle + 1'b1;
    end

    frame_addr_calc #(
        .CURRENT_LED_WIDTH (CURRENT_LED_WIDTH),
        .ANGLE_WIDTH       (ANGLE_WIDTH),
        .W_ADDR_WIDTH      (W_ADDR_WIDTH)
    ) u_addr (
        .i_angle  (w_angle),
        .i_half   (w_half),
        .i_led    (w_led),
        .i_color  (w_color),
        .o_offset (w_offset)
    );

    // FSM, index counters and the registered RAM write port; counters wrap to 0 after the last byte
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= ST_IDLE;
            r_angle  <= '0;
            r_half   <= 1'b0;
            r_led    <= '0;
            r_color  <= 2'd0;
            w_en     <= 1'b0;
            w_addr   <= '0;
            w_data   <= 8'd0;
            sync_err <= 1'b0;
        end else begin
            r_state  <= r_state == ST_DONE ? ST_IDLE :
                        (w_wr && w_last)   ? ST_DONE :
                        w_wr               ? ST_WRITE : r_state;
            w_en     <= w_wr;
            sync_err <= w_sof_err;
            if (w_wr) begin
                w_addr  <= (w_write_bank ? W_ADDR_WIDTH'(BANK_OFFSET) : '0) + w_offset;
                w_data  <= s_if.data_in;
                r_angle <= w_n_angle;
                r_half  <= w_n_half;
                r_led   <= w_n_led;
                r_color <= w_n_color;
            end
        end
    end
endmodule

// File: tb/tb_frame_ram_writer.sv
// tb_frame_ram_writer: random and directed stream stimulus checked against a frame-position reference model
module tb_frame_ram_writer;
    import litspin_pkg::*;
`ifdef FRAME_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int FRAME = 6144;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        w_en, rd_bank, frame_done, sync_err;
    logic [13:0] w_addr;
    logic [7:0]  w_data;
    logic [7:0]  dut_ram [0:16383];
    logic [7:0]  frame_d [0:FRAME-1];
    int          total = 0, bad = 0;
    int          m_state = 0, m_pos = 0, e_addr = 0, e_data = 0;
    bit          m_bank = 0, m_known = 0, e_wen = 0, e_err = 0;

    always #5 clk = ~clk;

    frame_ram_writer_if bus ();

    frame_ram_writer dut (
        .clk        (clk),
        .nrst       (nrst),
        .s_if       (bus),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always @(posedge clk) if (w_en === 1'b1) dut_ram[w_addr] <= w_data;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // one clock of stimulus; the model tracks the linear byte position in the frame
    task automatic cycle(bit v, logic [7:0] d, bit s, bit r);
        bus.data_valid = v;
        bus.data_in    = d;
        bus.sof        = s;
        nrst           = r;
        if (m_known) check("ready", 32'(bus.data_ready), 32'(m_state != 2));
        @(posedge clk);
        e_wen = 0;
        e_err = 0;
        if (!r) begin
            m_state = 0; m_pos = 0; m_bank = 0; e_addr = 0; e_data = 0;
            m_known = 1;
        end else if (m_state == 2) begin
            m_state = 0;
            if (DB) m_bank = ~m_bank;
        end else if (v && (s || m_state == 1)) begin
            if (s) begin
                e_err = m_state == 1;
                m_pos = 0;
            end
            e_wen   = 1;
            e_addr  = (DB && !m_bank ? BANK_OFFSET : 0) + m_pos;
            e_data  = d;
            m_state = 1;
            m_pos++;
            if (m_pos == FRAME) begin
                m_state = 2;
                m_pos   = 0;
            end
        end
        #1;
        if (m_known) begin
            check("w_en", 32'(w_en), 32'(e_wen));
            if (e_wen) begin
                check("w_addr", 32'(w_addr), e_addr);
                check("w_data", 32'(w_data), e_data);
            end
            check("frame_done", 32'(frame_done), 32'(m_state == 2));
            check("sync_err", 32'(sync_err), 32'(e_err));
            check("rd_bank", 32'(rd_bank), 32'(m_bank));
        end
    endtask

    task automatic run_frame(bit keep);
        int k = 0;
        logic [7:0] b;
        while (k < FRAME) begin
            b = 8'($urandom);
            if ($urandom_range(3) == 0) cycle(1'b0, b, 1'b0, 1'b1);
            else begin
                if (keep) frame_d[k] = b;
                cycle(1'b1, b, k == 0, 1'b1);
                if (k == 0) check("rand_first_off", 32'(w_addr) % BANK_OFFSET, 0);
                k++;
            end
        end
        cycle(1'($urandom), 8'($urandom), 1'b0, 1'b1);
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'd0;
        bus.sof        = 1'b0;
        repeat (2) cycle(1'b0, 8'd0, 1'b0, 1'b0);
        check("rst_w_en", 32'(w_en), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        check("rst_w_data", 32'(w_data), 0);
        check("rst_rd_bank", 32'(rd_bank), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b1);
            check("idle_drop", 32'(w_en), 0);
        end
        for (int k = 0; k < FRAME; k++) begin
            cycle(1'b1, k == 0 ? 8'hAA : 8'(k), k == 0, 1'b1);
            if (k == 0) begin
                check("first_addr", 32'(w_addr), DB ? 8192 : 0);
                check("first_data", 32'(w_data), 32'hAA);
            end
            if (k == 100) check("off100", 32'(w_addr), (DB ? 8192 : 0) + 100);
            if (k == 150) check("off150", 32'(w_addr), (DB ? 8192 : 0) + 150);
            if (k == FRAME - 1) begin
                check("off6143", 32'(w_addr), (DB ? 8192 : 0) + 6143);
                check("data6143", 32'(w_data), 32'hFF);
                check("done_pulse", 32'(frame_done), 1);
                check("done_ready", 32'(bus.data_ready), 0);
            end
        end
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        check("done_clear", 32'(frame_done), 0);
        check("bank_toggle", 32'(rd_bank), 32'(DB));
        for (int k = 0; k < 500; k++) cycle(1'b1, 8'($urandom), k == 0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b1, 1'b1);
        check("sync_pulse", 32'(sync_err), 1);
        check("sync_off", 32'(w_addr), 0);
        check("sync_data", 32'(w_data), 32'h5A);
        cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        check("sync_clear", 32'(sync_err), 0);
        check("after_sync_off", 32'(w_addr), 1);
        for (int k = 2; k < 3000; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("midrst_w_en", 32'(w_en), 0);
        check("midrst_bank", 32'(rd_bank), 0);
        check("midrst_done", 32'(frame_done), 0);
        run_frame(1'b0);
        check("bank_after_c", 32'(rd_bank), 32'(DB));
        run_frame(1'b1);
        check("bank_after_d", 32'(rd_bank), 0);
        for (int k = 0; k < FRAME; k += 97) check("ram_bank0", 32'(dut_ram[k]), 32'(frame_d[k]));
        check("ram_last", 32'(dut_ram[FRAME-1]), 32'(frame_d[FRAME-1]));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
